// File: rtl/mdu_pkg.sv
// Shared MDU op encodings for the E-stage multiply/divide scheduler.
package mdu_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for every multi-cycle MDU op,
// including divide-by-zero and the signed-divide overflow case.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  input  logic [31:0]        hi,
  input  logic [31:0]        lo,
  output logic [63:0]        result
);

  logic signed [63:0] sa_ext;
  logic signed [63:0] sb_ext;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        bs_safe;
  logic [31:0]        bu_safe;
  logic [31:0]        qs_mag;
  logic [31:0]        rs_mag;
  logic [31:0]        qs;
  logic [31:0]        rs;
  logic [31:0]        qu;
  logic [31:0]        ru;

  assign sa_ext = {{32{src_a[31]}}, src_a};
  assign sb_ext = {{32{src_b[31]}}, src_b};
  assign prod_s = sa_ext * sb_ext;
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign acc    = {hi, lo};

  // Signed divide on magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000/-1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign a_mag   = src_a[31] ? (32'd0 - src_a) : src_a;
  assign b_mag   = src_b[31] ? (32'd0 - src_b) : src_b;
  assign bs_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign bu_safe = (src_b == 32'd0) ? 32'd1 : src_b;
  assign qs_mag  = a_mag / bs_safe;
  assign rs_mag  = a_mag % bs_safe;
  assign qs      = (src_a[31] ^ src_b[31]) ? (32'd0 - qs_mag) : qs_mag;
  assign rs      = src_a[31] ? (32'd0 - rs_mag) : rs_mag;
  assign qu      = src_a / bu_safe;
  assign ru      = src_a % bu_safe;

  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF} : {rs, qs};
      MD_DIVU:  result = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF} : {ru, qu};
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// MDU scheduler: latency countdown, pending result, HI/LO and D-stage stall.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu as multi-cycle ops.
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  input  logic               d_is_md,
  output logic               busy,
  output logic               start,
  output logic               stall,
  output logic [31:0]        md_rdata
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  count_reg, count_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] hi_pend_reg, hi_pend_next;
  logic [31:0] lo_pend_reg, lo_pend_next;
  logic [63:0] arith_result;

  mdu_arith u_arith (
    .op     (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .result (arith_result)
  );

  always_comb begin
    start = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: start = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: start = 1'b1;
`endif
      default: start = 1'b0;
    endcase
  end

  assign busy  = (count_reg != 4'd0);
  assign stall = d_is_md & (start | busy);

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == MD_MFHI) md_rdata = hi_reg;
    else if (md_op == MD_MFLO) md_rdata = lo_reg;
  end

  // Anything arriving while busy is dropped; the commit happens on the
  // edge where the countdown leaves 1.
  always_comb begin
    count_next   = count_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    hi_pend_next = hi_pend_reg;
    lo_pend_next = lo_pend_reg;
    if (busy) begin
      count_next = count_reg - 4'd1;
      if (count_reg == 4'd1) begin
        hi_next = hi_pend_reg;
        lo_next = lo_pend_reg;
      end
    end else if (start) begin
      count_next   = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
      hi_pend_next = arith_result[63:32];
      lo_pend_next = arith_result[31:0];
    end else if (md_op == MD_MTHI) begin
      hi_next = src_a;
    end else if (md_op == MD_MTLO) begin
      lo_next = src_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      hi_pend_reg <= 32'd0;
      lo_pend_reg <= 32'd0;
    end else begin
      count_reg   <= count_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      hi_pend_reg <= hi_pend_next;
      lo_pend_reg <= lo_pend_next;
    end
  end

endmodule
